// File: rtl/mux4_select_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_select_arbiter
//
// Round-robin arbiter that drives the 2-bit select of a downstream 4:1 mux.
// Four requesters compete for the mux output. One owner holds the grant for
// at most MAX_HOLD consecutive cycles while others wait, then ownership
// rotates. All outputs are registered so the mux select is glitch-free.
//
// Build option:
//   MUX4_SELECT_FIXED_PRIO_EN  - when defined, arbitration is fixed priority
//                                (requester 0 highest). Hold expiry still
//                                applies. Ports, reset values and latency
//                                are identical in both builds.
//
// Parameters:
//   MAX_HOLD - max consecutive grant cycles while others wait (0 = unlimited)
//   CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous reset, active-high
//   req     in   4  level request vector, bit i = mux input i (A..D)
//   control out  2  registered mux select, index of current/last owner
//   grant   out  4  registered one-hot grant, zero when no owner
//   valid   out  1  registered, 1 when grant is non-zero
// ---------------------------------------------------------------------------
module mux4_select_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] control,
  output logic [3:0] grant,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               UNLIMITED = (MAX_HOLD == 0);

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [1:0]       last_reg,    last_next;
  logic [1:0]       control_reg, control_next;
  logic [3:0]       grant_reg,   grant_next;
  logic             valid_reg,   valid_next;

  // ---------------------------------------------------------------------
  // Winner search: rotate req so the search start sits at bit 0, pick the
  // lowest set bit, then rotate the offset back into an absolute index.
  // The owner itself is the last position searched, so a lone requester
  // is re-granted at hold expiry.
  // ---------------------------------------------------------------------
  logic [1:0] search_base;
  logic [3:0] req_rot;
  logic [1:0] offset;
  logic [1:0] winner;
  logic       any_req;

`ifdef MUX4_SELECT_FIXED_PRIO_EN
  assign search_base = 2'd0;
`else
  assign search_base = last_reg + 2'd1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[search_base + 2'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 2'd0;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
    else if (req_rot[3]) offset = 2'd3;
  end

  assign any_req = |req;
  assign winner  = search_base + offset;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_reg    <= 2'd3;  // first search starts at requester 0
      control_reg <= 2'b00;
      grant_reg   <= 4'b0000;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      control_reg <= control_next;
      grant_reg   <= grant_next;
      valid_reg   <= valid_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  logic keep;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    control_next = control_reg;
    grant_next   = grant_reg;
    valid_next   = valid_reg;
    keep         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next   = GRANT;
          grant_next   = 4'b0001 << winner;
          control_next = winner;
          valid_next   = 1'b1;
          cnt_next     = CNT_ONE;
          last_next    = winner;
        end else begin
          // control deliberately keeps the last owner's index
          grant_next = 4'b0000;
          valid_next = 1'b0;
        end
      end

      GRANT: begin
        keep = req[last_reg] && (UNLIMITED || (cnt_reg < HOLD_LIM));
        if (keep) begin
          // Saturation only matters for unlimited hold
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else if (any_req) begin
          // Direct hand-over, no idle bubble between owners
          grant_next   = 4'b0001 << winner;
          control_next = winner;
          valid_next   = 1'b1;
          cnt_next     = CNT_ONE;
          last_next    = winner;
        end else begin
          state_next = IDLE;
          grant_next = 4'b0000;
          valid_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign control = control_reg;
  assign grant   = grant_reg;
  assign valid   = valid_reg;

endmodule
